// File: rtl/p2s_stream_pkg.sv
// ============================================================================
// Module  : p2s_stream_pkg
// Brief   : Shared FSM state encodings and bit-order constants for p2s_stream.
// Revision: 1.0
// ============================================================================
`default_nettype none

package p2s_stream_pkg;

   localparam logic [1:0] c_ST_IDLE  = 2'd0;
   localparam logic [1:0] c_ST_SHIFT = 2'd1;
   localparam logic [1:0] c_ST_GAP   = 2'd2;

   localparam int c_MSB_FIRST = 0;
   localparam int c_LSB_FIRST = 1;

   localparam int c_GAP_CNT_W = 4;

endpackage

`default_nettype wire

// File: rtl/p2s_hold_reg.sv
// ============================================================================
// Module  : p2s_hold_reg
// Brief   : One-entry holding buffer that sits behind the serial shifter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module p2s_hold_reg #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic              full,
   output logic [DATA_W-1:0] data
);

   logic              r_full;
   logic [DATA_W-1:0] r_data;

   // Writes and reads never coincide: the top only writes while this entry is empty.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_full <= 1'b0;
         r_data <= '0;
      end else if (wr_en) begin
         r_full <= 1'b1;
         r_data <= wr_data;
      end else if (rd_en) begin
         r_full <= 1'b0;
      end
   end

   assign full = r_full;
   assign data = r_data;

endmodule

`default_nettype wire

// File: rtl/p2s_stream.sv
// ============================================================================
// Module  : p2s_stream
// Brief   : Parallel-to-serial converter with one-word hold buffer, sync/ack
//           outputs, selectable bit order and optional inter-word idle gap.
// Revision: 1.0
// ============================================================================
`default_nettype none

module p2s_stream
   import p2s_stream_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int LSB_FIRST = 0,
   parameter int IDLE_GAP  = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              valid,
   input  logic [DATA_W-1:0] data_in,
   output logic              ready,
   output logic              ack,
   output logic              data_out,
   output logic              sync,
   output logic              busy
);

   localparam int c_CNT_W = $clog2(DATA_W);
   localparam logic [c_CNT_W-1:0]     c_LAST_BIT   = c_CNT_W'(DATA_W - 1);
   localparam logic [c_GAP_CNT_W-1:0] c_GAP_RELOAD = c_GAP_CNT_W'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

   logic [1:0]             r_state;
   logic [DATA_W-1:0]      r_shift;
   logic [c_CNT_W-1:0]     r_bit_cnt;
   logic [c_GAP_CNT_W-1:0] r_gap_cnt;
   logic                   r_dout;
   logic                   r_sync;
   logic                   r_ack;

   logic              w_hold_full;
   logic [DATA_W-1:0] w_hold_data;
   logic              w_accept;
   logic              w_last;
   logic              w_gap_end;
   logic              w_word_done;
   logic              w_free;
   logic              w_direct;
   logic              w_hold_wr;
   logic              w_hold_rd;
   logic              w_load;
   logic [DATA_W-1:0] w_load_word;
   logic              w_first_bit;
   logic [DATA_W-1:0] w_load_shift;
   logic              w_next_bit;
   logic [DATA_W-1:0] w_next_shift;

   assign ready    = !w_hold_full;
   assign w_accept = valid && ready;

   assign w_last      = (r_state == c_ST_SHIFT) && (r_bit_cnt == c_LAST_BIT);
   assign w_gap_end   = (r_state == c_ST_GAP) && (r_gap_cnt == '0);
   assign w_word_done = (w_last && (IDLE_GAP == 0)) || w_gap_end;

   // A word arriving exactly when the shifter would go idle is loaded directly,
   // so the hold register only ever buffers a word that must wait.
   assign w_free      = (r_state == c_ST_IDLE) || (w_word_done && !w_hold_full);
   assign w_direct    = w_accept && w_free;
   assign w_hold_wr   = w_accept && !w_free;
   assign w_hold_rd   = w_word_done && w_hold_full;
   assign w_load      = w_direct || w_hold_rd;
   assign w_load_word = w_direct ? data_in : w_hold_data;

   generate
      if (LSB_FIRST == c_LSB_FIRST) begin : g_lsb_first
         assign w_first_bit  = w_load_word[0];
         assign w_load_shift = {1'b0, w_load_word[DATA_W-1:1]};
         assign w_next_bit   = r_shift[0];
         assign w_next_shift = {1'b0, r_shift[DATA_W-1:1]};
      end else begin : g_msb_first
         assign w_first_bit  = w_load_word[DATA_W-1];
         assign w_load_shift = {w_load_word[DATA_W-2:0], 1'b0};
         assign w_next_bit   = r_shift[DATA_W-1];
         assign w_next_shift = {r_shift[DATA_W-2:0], 1'b0};
      end
   endgenerate

   p2s_hold_reg #(
      .DATA_W (DATA_W)
   ) u_hold (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (w_hold_wr),
      .wr_data (data_in),
      .rd_en   (w_hold_rd),
      .full    (w_hold_full),
      .data    (w_hold_data)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= c_ST_IDLE;
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_gap_cnt <= '0;
         r_dout    <= 1'b0;
         r_sync    <= 1'b0;
         r_ack     <= 1'b0;
      end else begin
         r_ack  <= w_accept;
         r_sync <= w_load;
         if (w_load) begin
            r_state   <= c_ST_SHIFT;
            r_shift   <= w_load_shift;
            r_bit_cnt <= '0;
            r_dout    <= w_first_bit;
         end else begin
            case (r_state)
               c_ST_SHIFT: begin
                  if (w_last) begin
                     r_dout <= 1'b0;
                     if (IDLE_GAP > 0) begin
                        r_state   <= c_ST_GAP;
                        r_gap_cnt <= c_GAP_RELOAD;
                     end else begin
                        r_state <= c_ST_IDLE;
                     end
                  end else begin
                     r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
                     r_shift   <= w_next_shift;
                     r_dout    <= w_next_bit;
                  end
               end
               c_ST_GAP: begin
                  r_dout <= 1'b0;
                  if (r_gap_cnt == '0) begin
                     r_state <= c_ST_IDLE;
                  end else begin
                     r_gap_cnt <= r_gap_cnt - c_GAP_CNT_W'(1);
                  end
               end
               default: begin
                  r_state <= c_ST_IDLE;
                  r_dout  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign ack      = r_ack;
   assign data_out = r_dout;
   assign sync     = r_sync;
   assign busy     = (r_state != c_ST_IDLE);

endmodule

`default_nettype wire
